// File: rtl/imem_fetch_resp.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_resp
// Purpose  : Instruction-fetch response unit. Accepts one fetch request at a
//            time from the IF stage, issues a single memory read and returns
//            the instruction (or a NOP with an error cause) as a held
//            valid/ready response.
// Ports    : clk, reset (async, active-low)
//            cpu_en, flush               - core enable / branch-taken discard
//            fetch_valid/ready, fetch_pc - request handshake and byte address
//            rsp_valid/ready, rsp_insn,
//            rsp_pc, rsp_cause           - response (00 ok, 01 misaligned,
//                                          10 bus timeout)
//            bus_req, bus_addr,
//            bus_ack, bus_rdata          - memory read port
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_resp #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSN_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_en,
    input  logic                  fetch_valid,
    output logic                  fetch_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [INSN_WIDTH-1:0] rsp_insn,
    output logic [ADDR_WIDTH-1:0] rsp_pc,
    output logic [1:0]            rsp_cause,
    output logic                  bus_req,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic                  bus_ack,
    input  logic [INSN_WIDTH-1:0] bus_rdata
);

    localparam int                  CNT_W          = $clog2(TIMEOUT + 1);
    // Wait count seen in the last permitted bus cycle.
    localparam logic [CNT_W-1:0]    CNT_LAST       = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX        = CNT_W'(TIMEOUT);
    localparam logic [INSN_WIDTH-1:0] NOP_INSN     = INSN_WIDTH'(32'h0000_0013);
    localparam logic [1:0]          CAUSE_OK       = 2'b00;
    localparam logic [1:0]          CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]          CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q,    pc_d;
    logic [INSN_WIDTH-1:0]   insn_q,  insn_d;
    logic [1:0]              cause_q, cause_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;

    logic accept;
    logic abort;
    logic bus_expire;

    assign fetch_ready = (state_q == ST_IDLE) & cpu_en & ~flush;
    assign accept      = fetch_valid & fetch_ready;
    assign abort       = flush | ~cpu_en;
    // True in the bus cycle that exhausts the wait budget.
    assign bus_expire  = (cnt_q == CNT_LAST);

    assign bus_req   = (state_q == ST_BUS) | (state_q == ST_DRAIN);
    assign bus_addr  = pc_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_insn  = insn_q;
    assign rsp_pc    = pc_q;
    assign rsp_cause = cause_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pc_d  = fetch_pc;
                    cnt_d = '0;
                    if (fetch_pc[1:0] == 2'b00) begin
                        state_d = ST_BUS;
                    end else begin
                        state_d = ST_RESP;
                        insn_d  = NOP_INSN;
                        cause_d = CAUSE_MISALIGN;
                    end
                end
            end

            ST_BUS: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (abort) begin
                    // The read is already on the bus; if it completes this
                    // cycle there is nothing left to drain.
                    state_d = (bus_ack | bus_expire) ? ST_IDLE : ST_DRAIN;
                end else if (bus_ack) begin
                    state_d = ST_RESP;
                    insn_d  = bus_rdata;
                    cause_d = CAUSE_OK;
                end else if (bus_expire) begin
                    state_d = ST_RESP;
                    insn_d  = NOP_INSN;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            ST_DRAIN: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (bus_ack | bus_expire) state_d = ST_IDLE;
            end

            ST_RESP: begin
                if (rsp_ready | abort) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            insn_q  <= '0;
            cause_q <= CAUSE_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire
